multicycle_control: RTL
=======================

# multicycle_control

Multi-cycle MIPS main control FSM. Sequences fetch, decode, execute, memory and writeback for one instruction at a time, driving the datapath muxes, register/memory enables and the 3-bit ALU operation code consumed by the ALU control decoder. It handshakes with a variable-latency memory port and sits between the instruction register and the shared ALU/register-file/memory datapath.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- opcode  in  6  inst[31:26] from the instruction register; stable from DECODE onward.
- funct  in  6  inst[5:0] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  PC load enable.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  writeback data select: 0 = ALUOut, 1 = MDR.
- reg_dst  out  1  destination select: 0 = rt, 1 = rd.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  00 = B, 01 = 4, 10 = immediate, 11 = immediate << 2.
- ext_zero  out  1  immediate zero-extended (1) or sign-extended (0).
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = A (jr).
- aluop  out  3  000 add, 001 sub, 010 R-type (funct), 100 and, 101 or.
- state  out  4  current state encoding, for debug.
- illegal  out  1  sticky flag set on an undefined opcode.
- cycle_cnt  out  CNT_W  cycles since reset (feature-dependent).
- instr_cnt  out  CNT_W  retired instructions (feature-dependent).

## Operation
- States and encodings: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, R_EXEC 7, R_WB 8, BRANCH 9, JUMP 10, JR 11, I_EXEC 12, I_WB 13, TRAP 14.
- Outputs are decoded from the state; they default to 0 unless listed below.
- IDLE: all outputs 0. Goes to FETCH on the next cycle.
- FETCH: mem_read=1, alu_src_b=01, aluop=000.
  - While mem_ready=1: ir_write=1, pc_write=1, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_b=11, aluop=000 (branch target). Next state by opcode:
  - 000000 with funct 001000 goes to JR; any other 000000 goes to R_EXEC.
  - 100011 (lw) and 101011 (sw) go to MEM_ADDR.
  - 000100 (beq) and 000101 (bne) go to BRANCH.
  - 000010 (j) goes to JUMP.
  - 001000 (addi), 001100 (andi) and 001101 (ori) go to I_EXEC.
  - Any other opcode goes to TRAP.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, aluop=000. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Goes to FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ready, then goes to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, aluop=010. Goes to R_WB.
- R_WB: reg_write=1, reg_dst=1. Goes to FETCH.
- BRANCH: alu_src_a=1, aluop=001, pc_source=01.
  - pc_write = zero for beq, ~zero for bne.
  - Goes to FETCH.
- JUMP: pc_write=1, pc_source=10. Goes to FETCH.
- JR: pc_write=1, pc_source=11. Goes to FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10.
  - addi: aluop=000, ext_zero=0.
  - andi: aluop=100, ext_zero=1.
  - ori: aluop=101, ext_zero=1.
  - Goes to I_WB.
- I_WB: reg_write=1, reg_dst=0. Goes to FETCH.
- TRAP: all enables 0, illegal=1. The FSM stays in TRAP until reset.

## Timing
- Reset (reset_n=0) asynchronously forces:
  - state to IDLE;
  - all outputs to 0, including illegal and both counters.
- Reset asserted mid-access drops mem_read/mem_write immediately; no partial writeback occurs.
- Minimum latency per instruction, with mem_ready=1 on the first cycle of each access:
  - lw: 5 cycles.
  - sw, R-type, addi/andi/ori: 4 cycles.
  - beq/bne, j, jr: 3 cycles.
- Each cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle. mem_read/mem_write stay high and i_or_d stays stable until the completing cycle.
- mem_ready is ignored in every state except FETCH, MEM_RD and MEM_WR.
- zero is sampled only in BRANCH.
- An instruction retires on the cycle the FSM leaves MEM_WB, MEM_WR, R_WB, BRANCH, JUMP, JR or I_WB.

## Configuration
- Macro MCCTRL_PERF_EN.
- Defined:
  - cycle_cnt increments every cycle outside IDLE.
  - instr_cnt increments on each retirement.
  - Both wrap modulo 2^CNT_W and freeze in TRAP.
- Undefined: both ports are tied to 0 and no counter registers are built.

## Test plan
- Reset, then mem_ready=1 constantly, R-type add (opcode 000000, funct 100000):
  - state sequence 1,2,7,8,1;
  - aluop=010 in R_EXEC;
  - reg_write=1, reg_dst=1 in R_WB.
- lw with mem_ready low for 2 cycles in MEM_RD:
  - MEM_RD lasts 3 cycles with mem_read=1, i_or_d=1;
  - MEM_WB follows with mem_to_reg=1;
  - instr_cnt increments by 1.
- beq: zero=1 gives pc_write=1 with pc_source=01; zero=0 gives pc_write=0. bne with zero=0 gives pc_write=1.
- Sequence ori, then jr (000000/001000):
  - ori: ext_zero=1, aluop=101.
  - jr: the JR state, pc_source=11, pc_write=1, 3 cycles total.
- Opcode 111111:
  - TRAP entered after DECODE, illegal=1 and held;
  - counters frozen;
  - reset_n pulse clears illegal and returns to IDLE.
- reset_n asserted during MEM_WR wait: mem_write drops to 0 in the same cycle; the counters read 0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM with a memory ready handshake.
// Define MCCTRL_PERF_EN to build the cycle/instruction performance counters.
module multicycle_control #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_to_reg,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic             ext_zero,
   output logic [1:0]       pc_source,
   output logic [2:0]       aluop,
   output logic [3:0]       state,
   output logic             illegal,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt
);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_FETCH    = 4'd1;
   localparam logic [3:0] S_DECODE   = 4'd2;
   localparam logic [3:0] S_MEM_ADDR = 4'd3;
   localparam logic [3:0] S_MEM_RD   = 4'd4;
   localparam logic [3:0] S_MEM_WB   = 4'd5;
   localparam logic [3:0] S_MEM_WR   = 4'd6;
   localparam logic [3:0] S_R_EXEC   = 4'd7;
   localparam logic [3:0] S_R_WB     = 4'd8;
   localparam logic [3:0] S_BRANCH   = 4'd9;
   localparam logic [3:0] S_JUMP     = 4'd10;
   localparam logic [3:0] S_JR       = 4'd11;
   localparam logic [3:0] S_I_EXEC   = 4'd12;
   localparam logic [3:0] S_I_WB     = 4'd13;
   localparam logic [3:0] S_TRAP     = 4'd14;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] FN_JR    = 6'b001000;

   logic [3:0] r_state;
   logic [3:0] w_next;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:     w_next = S_FETCH;
         S_FETCH:    if (mem_ready) w_next = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:                  w_next = (funct == FN_JR) ? S_JR : S_R_EXEC;
               OP_LW, OP_SW:              w_next = S_MEM_ADDR;
               OP_BEQ, OP_BNE:            w_next = S_BRANCH;
               OP_J:                      w_next = S_JUMP;
               OP_ADDI, OP_ANDI, OP_ORI:  w_next = S_I_EXEC;
               default:                   w_next = S_TRAP;
            endcase
         end
         S_MEM_ADDR: w_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   if (mem_ready) w_next = S_MEM_WB;
         S_MEM_WR:   if (mem_ready) w_next = S_FETCH;
         S_R_EXEC:   w_next = S_R_WB;
         S_I_EXEC:   w_next = S_I_WB;
         S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_JR, S_I_WB: w_next = S_FETCH;
         S_TRAP:     w_next = S_TRAP;
         default:    w_next = S_IDLE;
      endcase
   end

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      pc_write   = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      mem_to_reg = 1'b0;
      reg_dst    = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      ext_zero   = 1'b0;
      pc_source  = 2'b00;
      aluop      = 3'b000;
      illegal    = 1'b0;
      case (r_state)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE:   alu_src_b = 2'b11;
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
         end
         S_R_EXEC: begin
            alu_src_a = 1'b1;
            aluop     = 3'b010;
         end
         S_R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            aluop     = 3'b001;
            pc_source = 2'b01;
            pc_write  = (opcode == OP_BNE) ? ~zero : zero;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
         end
         S_JR: begin
            pc_write  = 1'b1;
            pc_source = 2'b11;
         end
         S_I_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            if (opcode == OP_ANDI) begin
               aluop    = 3'b100;
               ext_zero = 1'b1;
            end else if (opcode == OP_ORI) begin
               aluop    = 3'b101;
               ext_zero = 1'b1;
            end
         end
         S_I_WB:     reg_write = 1'b1;
         S_TRAP:     illegal = 1'b1;
         default:    ;
      endcase
   end

   assign state = r_state;

`ifdef MCCTRL_PERF_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] r_cycle_cnt;
   logic [CNT_W-1:0] r_instr_cnt;
   logic             w_retire;

   // MEM_WR is the only retiring state that can hold, so it retires on mem_ready.
   assign w_retire = (r_state inside {S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_JR, S_I_WB}) ||
                     ((r_state == S_MEM_WR) && mem_ready);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cycle_cnt <= '0;
         r_instr_cnt <= '0;
      end else begin
         if ((r_state != S_IDLE) && (r_state != S_TRAP)) r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
         if (w_retire) r_instr_cnt <= r_instr_cnt + CNT_ONE;
      end
   end

   assign cycle_cnt = r_cycle_cnt;
   assign instr_cnt = r_instr_cnt;
`else
   assign cycle_cnt = '0;
   assign instr_cnt = '0;
`endif

endmodule
